// File: rtl/schmu_pkg.sv
// Shared definitions for schmu: operation encodings and the combine function.
// The OP encoding is fixed; any unlisted code falls back to AND.
package schmu_pkg;

    localparam int unsigned OP_AND  = 32'd0;
    localparam int unsigned OP_OR   = 32'd1;
    localparam int unsigned OP_XOR  = 32'd2;
    localparam int unsigned OP_NAND = 32'd3;
    localparam int unsigned OP_NOR  = 32'd4;
    localparam int unsigned OP_XNOR = 32'd5;

    function automatic logic schmu_apply_op(input int unsigned op, input logic a, input logic b);
        logic r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            default: r = a & b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/schmu_filter.sv
// Single-bit glitch filter: the held value follows the input only after the
// input has differed from it for FILTER_LEN consecutive cycles.
module schmu_filter #(
    parameter int unsigned FILTER_LEN = 32'd4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       hold_q;
    logic       hold_d;

    // Next-state: count consecutive disagreements, flip the held value on the last one.
    always_comb begin
        cnt_d  = 4'd0;
        hold_d = hold_q;
        if (d_i != hold_q) begin
            if (cnt_q == 4'(FILTER_LEN - 32'd1)) begin
                hold_d = d_i;
                cnt_d  = 4'd0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end else begin
            cnt_d = 4'd0;
        end
    end

    // Counter and held-value registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= 4'd0;
            hold_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
        end
    end

    assign q_o = hold_q;

endmodule

// File: rtl/schmu.sv
// schmu: synchronized two-input logic gate with a registered output.
// Optional per-operand glitch filter enabled by macro SCHMU_FILTER_EN.
module schmu
    import schmu_pkg::*;
#(
    parameter int unsigned OP          = 32'd0,
    parameter int unsigned SYNC_STAGES = 32'd2,
    parameter int unsigned FILTER_LEN  = 32'd4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic x,
    input  logic y,
    output logic XLXN_9
);

    logic [1:0]             rst_sync_q;
    logic                   rst_pipe_n;
    logic [SYNC_STAGES-1:0] x_sync_q;
    logic [SYNC_STAGES-1:0] x_sync_d;
    logic [SYNC_STAGES-1:0] y_sync_q;
    logic [SYNC_STAGES-1:0] y_sync_d;
    logic                   a_s;
    logic                   b_s;
    logic                   out_q;
    logic                   out_d;

    // Reset synchronizer: asserts immediately, releases the pipeline two edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_pipe_n = rst_sync_q[1];

    // Shift each operand one stage deeper into its synchronizer chain.
    always_comb begin
        x_sync_d = {x_sync_q[SYNC_STAGES-2:0], x};
        y_sync_d = {y_sync_q[SYNC_STAGES-2:0], y};
    end

    // Synchronizer flops for both operands.
    always_ff @(posedge clk or negedge rst_pipe_n) begin
        if (!rst_pipe_n) begin
            x_sync_q <= '0;
            y_sync_q <= '0;
        end else begin
            x_sync_q <= x_sync_d;
            y_sync_q <= y_sync_d;
        end
    end

`ifdef SCHMU_FILTER_EN
    schmu_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_x (
        .clk_i  (clk),
        .rst_ni (rst_pipe_n),
        .d_i    (x_sync_q[SYNC_STAGES-1]),
        .q_o    (a_s)
    );

    schmu_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_y (
        .clk_i  (clk),
        .rst_ni (rst_pipe_n),
        .d_i    (y_sync_q[SYNC_STAGES-1]),
        .q_o    (b_s)
    );
`else
    logic unused_filter_len_s;

    assign a_s = x_sync_q[SYNC_STAGES-1];
    assign b_s = y_sync_q[SYNC_STAGES-1];
    assign unused_filter_len_s = |FILTER_LEN;
`endif

    // Combine the cleaned operands with the selected operation.
    always_comb begin
        out_d = schmu_apply_op(OP, a_s, b_s);
    end

    // Single output flop; both operands land here on the same edge, so no glitch.
    always_ff @(posedge clk or negedge rst_pipe_n) begin
        if (!rst_pipe_n) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out_d;
        end
    end

    assign XLXN_9 = out_q;

endmodule

// File: tb/tb_schmu.sv
// Directed bench for schmu: one instance per OP code (0..5 and illegal 7),
// outputs packed as outs[6:0] = {OP7, XNOR, NOR, NAND, XOR, OR, AND}.
module tb_schmu;

`ifdef SCHMU_FILTER_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif

    localparam int unsigned OPS [7] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd7};

    // Hand-derived truth rows for {OP7, XNOR, NOR, NAND, XOR, OR, AND}
    localparam logic [6:0] E00 = 7'b0111000;
    localparam logic [6:0] E01 = 7'b0001110;
    localparam logic [6:0] E10 = 7'b0001110;
    localparam logic [6:0] E11 = 7'b1100011;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       x;
    logic       y;
    logic [6:0] outs;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 7; g++) begin : g_dut
        schmu #(.OP(OPS[g]), .SYNC_STAGES(32'd2), .FILTER_LEN(32'd4)) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .x      (x),
            .y      (y),
            .XLXN_9 (outs[g])
        );
    end

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] seq  [5];
        logic [6:0] erow [5];
        logic [6:0] prev;
        logic [6:0] exp;

        seq[0] = 2'b00; erow[0] = E00;
        seq[1] = 2'b01; erow[1] = E01;
        seq[2] = 2'b10; erow[2] = E10;
        seq[3] = 2'b11; erow[3] = E11;
        seq[4] = 2'b00; erow[4] = E00;

        x = 1'b0;
        y = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_hold", outs, 7'b0000000);

        // Release at a falling edge: sync takes 2 edges, output loads on the 3rd
        rst_n = 1'b1;
        @(negedge clk);
        check("release_e1", outs, 7'b0000000);
        @(negedge clk);
        check("release_e2", outs, 7'b0000000);
        @(negedge clk);
        check("release_e3", outs, E00);
        repeat (LAT + 2) @(negedge clk);
        check("idle_00", outs, E00);

        // Sweep; every cycle is checked so any intermediate glitch is caught
        prev = E00;
        for (int i = 0; i < 5; i++) begin
            {x, y} = seq[i];
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                exp = (k < LAT) ? prev : erow[i];
                check($sformatf("sweep%0d_k%0d", i, k), outs, exp);
            end
            prev = erow[i];
        end

        // Mid-cycle asynchronous reset with x=y=1
        x = 1'b1;
        y = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        check("pre_async_11", outs, E11);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", outs, 7'b0000000);
        @(negedge clk);
        check("async_hold", outs, 7'b0000000);
        rst_n = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k <= 2)
                exp = 7'b0000000;
            else if (k < 2 + LAT)
                exp = E00;
            else
                exp = E11;
            check($sformatf("post_async_k%0d", k), outs, exp);
        end

        // Pulse tests on x with y=1, observing the AND instance
        x = 1'b0;
        y = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        check("pulse_base", outs, E01);
`ifdef SCHMU_FILTER_EN
        x = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 3) x = 1'b0;
            check($sformatf("pulse3_k%0d", k), {6'b000000, outs[0]}, 7'b0000000);
        end
        x = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 4) x = 1'b0;
            exp = (k >= 7 && k <= 10) ? 7'b0000001 : 7'b0000000;
            check($sformatf("pulse4_k%0d", k), {6'b000000, outs[0]}, exp);
        end
`else
        x = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 2) x = 1'b0;
            exp = (k == 3 || k == 4) ? 7'b0000001 : 7'b0000000;
            check($sformatf("pulse2_k%0d", k), {6'b000000, outs[0]}, exp);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
